// File: rtl/puf_serial_param_if.sv
// puf_serial_param_if: bundles the handshake, challenge/response and ring-oscillator
// signals of puf_serial_param.
//   master modport: host side. It drives start, challenge and the oscillator banks, and
//                   observes ro_enable, busy, done, response and resp_valid.
//   slave modport : the PUF core.
interface puf_serial_param_if #(
    parameter int unsigned NUM_RO = 16,
    parameter int unsigned CHAL_W = 8,
    parameter int unsigned RESP_W = 8
) ();
    logic              start;
    logic [CHAL_W-1:0] challenge;
    logic [NUM_RO-1:0] ro_a;
    logic [NUM_RO-1:0] ro_b;
    logic              ro_enable;
    logic              busy;
    logic              done;
    logic [RESP_W-1:0] response;
    logic              resp_valid;

    modport master (
        output start, challenge, ro_a, ro_b,
        input  ro_enable, busy, done, response, resp_valid
    );

    modport slave (
        input  start, challenge, ro_a, ro_b,
        output ro_enable, busy, done, response, resp_valid
    );
endinterface

// File: rtl/puf_serial_param.sv
// puf_serial_param: serial ring-oscillator PUF response generator.
// A challenge seeds a 16-bit LFSR. For each response bit the LFSR steps once and selects
// one oscillator from bank A and one from bank B. Rising edges of both are counted over a
// fixed window, and the bit is 1 when bank A produced more edges than bank B.
// Ports:
//   clock  : system clock
//   reset  : synchronous, active-low reset
//   bus_io : slave modport of puf_serial_param_if
//            (start/challenge in, ro_a/ro_b in, ro_enable/busy/done/response/resp_valid out)
// Optional feature: define PUF_MAJORITY_VOTE_EN to measure every bit three times on the
// same oscillator pair and keep the majority result.
module puf_serial_param #(
    parameter int unsigned NUM_RO = 16,
    parameter int unsigned CHAL_W = 8,
    parameter int unsigned RESP_W = 8,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned WINDOW = 1024,
    parameter int unsigned SETTLE = 4
) (
    input logic                  clock,
    input logic                  reset,
    puf_serial_param_if.slave    bus_io
);
    localparam int unsigned SEL_W   = $clog2(NUM_RO);
    localparam int unsigned TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX);
    localparam int unsigned IDX_W   = (RESP_W > 1) ? $clog2(RESP_W) : 1;

    typedef enum logic [2:0] {StIdle, StSettle, StCount, StCompare, StDone} state_e;

    state_e             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic [RESP_W-1:0]  shift_q, shift_d, response_q, response_d;
    logic               resp_valid_q, resp_valid_d;
    logic               busy_q, busy_d, done_q, done_d, ro_enable_q, ro_enable_d;
    logic [2:0]         sync_a_q, sync_b_q;
    logic               last_trial, res_bit, cmp;
    logic [15:0]        seed;

`ifdef PUF_MAJORITY_VOTE_EN
    logic [1:0]         trial_q, trial_d;
    logic [1:0]         votes_q, votes_d;
`endif

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    wire logic [SEL_W-1:0] sel_a   = lfsr_q[SEL_W-1:0];
    wire logic [SEL_W-1:0] sel_b   = lfsr_q[2*SEL_W-1:SEL_W];
    // Bits [1:0] form the synchroniser and bit 2 holds the previous sample for edge detect.
    wire logic             edge_a  = sync_a_q[1] & ~sync_a_q[2];
    wire logic             edge_b  = sync_b_q[1] & ~sync_b_q[2];
    wire logic             set_last = (tmr_q == TMR_W'(SETTLE - 1));
    wire logic             cnt_last = (tmr_q == TMR_W'(WINDOW - 1));
    wire logic             idx_last = (idx_q == IDX_W'(RESP_W - 1));

    always_comb begin
        seed = '0;
        seed[CHAL_W-1:0] = bus_io.challenge;
        seed = seed ^ 16'hACE1;
        if (seed == 16'h0000) begin
            seed = 16'h0001;
        end
    end

`ifdef PUF_MAJORITY_VOTE_EN
    assign last_trial = (trial_q == 2'd2);
`else
    assign last_trial = 1'b1;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (bus_io.start) state_d = StSettle;
            StSettle:  if (set_last)     state_d = StCount;
            StCount:   if (cnt_last)     state_d = StCompare;
            StCompare: state_d = (last_trial && idx_last) ? StDone : StSettle;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output logic. Handshake outputs are registered from the current state, so done,
    // busy and resp_valid change together one cycle after DONE is entered.
    always_comb begin
        busy_d      = state_q inside {StSettle, StCount, StCompare};
        done_d      = (state_q == StDone);
        ro_enable_d = state_d inside {StSettle, StCount};
    end

    // Datapath next-state
    always_comb begin
        lfsr_d       = lfsr_q;
        idx_d        = idx_q;
        cnt_a_d      = cnt_a_q;
        cnt_b_d      = cnt_b_q;
        shift_d      = shift_q;
        response_d   = response_q;
        resp_valid_d = resp_valid_q;
        tmr_d        = (state_d != state_q || state_q == StIdle) ? '0 : tmr_q + 1'b1;
        cmp          = (cnt_a_q > cnt_b_q);
        res_bit      = cmp;
`ifdef PUF_MAJORITY_VOTE_EN
        trial_d      = trial_q;
        votes_d      = votes_q;
        res_bit      = (votes_q[0] & votes_q[1]) | (votes_q[0] & cmp) | (votes_q[1] & cmp);
`endif
        unique case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    lfsr_d       = lfsr_step(seed);
                    idx_d        = '0;
                    shift_d      = '0;
                    resp_valid_d = 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
                    trial_d      = '0;
`endif
                end
            end
            StCount: begin
                if (edge_a && cnt_a_q != '1) cnt_a_d = cnt_a_q + 1'b1;
                if (edge_b && cnt_b_q != '1) cnt_b_d = cnt_b_q + 1'b1;
            end
            StCompare: begin
                cnt_a_d = '0;
                cnt_b_d = '0;
`ifdef PUF_MAJORITY_VOTE_EN
                if (!last_trial) begin
                    votes_d[trial_q[0]] = cmp;
                    trial_d             = trial_q + 2'd1;
                end else begin
                    trial_d = '0;
                end
`endif
                if (last_trial) begin
                    shift_d = (shift_q << 1) | RESP_W'(res_bit);
                    if (!idx_last) begin
                        // Next bit: fresh oscillator pair.
                        lfsr_d = lfsr_step(lfsr_q);
                        idx_d  = idx_q + 1'b1;
                    end
                end
            end
            StDone: begin
                response_d   = shift_q;
                resp_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            lfsr_q       <= '0;
            tmr_q        <= '0;
            idx_q        <= '0;
            cnt_a_q      <= '0;
            cnt_b_q      <= '0;
            shift_q      <= '0;
            response_q   <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ro_enable_q  <= 1'b0;
            sync_a_q     <= '0;
            sync_b_q     <= '0;
        end else begin
            lfsr_q       <= lfsr_d;
            tmr_q        <= tmr_d;
            idx_q        <= idx_d;
            cnt_a_q      <= cnt_a_d;
            cnt_b_q      <= cnt_b_d;
            shift_q      <= shift_d;
            response_q   <= response_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ro_enable_q  <= ro_enable_d;
            sync_a_q     <= {sync_a_q[1:0], bus_io.ro_a[sel_a]};
            sync_b_q     <= {sync_b_q[1:0], bus_io.ro_b[sel_b]};
        end
    end

`ifdef PUF_MAJORITY_VOTE_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            trial_q <= '0;
            votes_q <= '0;
        end else begin
            trial_q <= trial_d;
            votes_q <= votes_d;
        end
    end
`endif

    assign bus_io.ro_enable  = ro_enable_q;
    assign bus_io.busy       = busy_q;
    assign bus_io.done       = done_q;
    assign bus_io.response   = response_q;
    assign bus_io.resp_valid = resp_valid_q;
endmodule

// File: tb/tb_puf_serial_param.sv
// tb_puf_serial_param: directed bench for puf_serial_param. A second instance with a
// 3-bit counter sees the same stimulus to expose counter saturation.
module tb_puf_serial_param;
    localparam int unsigned NUM_RO = 16;
    localparam int unsigned CHAL_W = 8;
    localparam int unsigned RESP_W = 8;
    localparam int unsigned WINDOW = 64;
    localparam int unsigned SETTLE = 4;
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int unsigned M = 3;
`else
    localparam int unsigned M = 1;
`endif
    localparam int unsigned LAT = 1 + RESP_W * M * (SETTLE + WINDOW + 1);

    typedef struct {
        string             tag;
        logic [RESP_W-1:0] exp;
        logic [RESP_W-1:0] exp_sat;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    puf_serial_param_if #(.NUM_RO(NUM_RO), .CHAL_W(CHAL_W), .RESP_W(RESP_W)) bus ();
    puf_serial_param_if #(.NUM_RO(NUM_RO), .CHAL_W(CHAL_W), .RESP_W(RESP_W)) sat_bus ();

    puf_serial_param #(
        .NUM_RO(NUM_RO), .CHAL_W(CHAL_W), .RESP_W(RESP_W),
        .CNT_W(16), .WINDOW(WINDOW), .SETTLE(SETTLE)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus_io(bus.slave)
    );

    puf_serial_param #(
        .NUM_RO(NUM_RO), .CHAL_W(CHAL_W), .RESP_W(RESP_W),
        .CNT_W(3), .WINDOW(WINDOW), .SETTLE(SETTLE)
    ) dut_sat (
        .clock (clock),
        .reset (reset),
        .bus_io(sat_bus.slave)
    );

    assign sat_bus.start     = bus.start;
    assign sat_bus.challenge = bus.challenge;
    assign sat_bus.ro_a      = bus.ro_a;
    assign sat_bus.ro_b      = bus.ro_b;

    // Oscillator stimulus: masked lines toggle with the given period, others stay low.
    logic [NUM_RO-1:0] mask_a = '0;
    logic [NUM_RO-1:0] mask_b = '0;
    int unsigned       per_a  = 4;
    int unsigned       per_b  = 4;
    int unsigned       cyc_free = 0;

    always @(negedge clock) begin
        logic [NUM_RO-1:0] va, vb;
        cyc_free = cyc_free + 1;
        for (int k = 0; k < NUM_RO; k++) begin
            va[k] = mask_a[k] && ((cyc_free % per_a) < per_a / 2);
            vb[k] = mask_b[k] && ((cyc_free % per_b) < per_b / 2);
        end
        bus.ro_a = va;
        bus.ro_b = vb;
    end

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] v);
        logic fb;
        fb = v[15] ^ v[13] ^ v[12] ^ v[10];
        return {v[14:0], fb};
    endfunction

    function automatic logic [15:0] seed_of(input logic [7:0] chal);
        logic [15:0] s;
        s = {8'h00, chal} ^ 16'hACE1;
        if (s == 16'h0000) s = 16'h0001;
        return s;
    endfunction

    function automatic logic [3:0] sel_a_of(input logic [7:0] chal, input int bit_i);
        logic [15:0] l;
        l = seed_of(chal);
        for (int i = 0; i <= bit_i; i++) l = step(l);
        return l[3:0];
    endfunction

    // Reference response: ideal edge counts per window, clipped at cap.
    function automatic logic [RESP_W-1:0] model(input logic [7:0] chal, input int unsigned cap);
        logic [15:0]       l;
        logic [RESP_W-1:0] r;
        int unsigned       ca, cb;
        l = seed_of(chal);
        r = '0;
        for (int i = 0; i < RESP_W; i++) begin
            l  = step(l);
            ca = mask_a[l[3:0]] ? WINDOW / per_a : 0;
            cb = mask_b[l[7:4]] ? WINDOW / per_b : 0;
            if (ca > cap) ca = cap;
            if (cb > cap) cb = cap;
            r = {r[RESP_W-2:0], (ca > cb)};
        end
        return r;
    endfunction

    // One evaluation. poke: extra start pulse at cycle 20. abort_at: assert reset there.
    task automatic run(input string tag, input logic [7:0] chal, input bit poke,
                       input int unsigned abort_at);
        exp_t        e;
        int unsigned cyc;
        if (abort_at == 0) begin
            e.tag     = tag;
            e.exp     = model(chal, 65535);
            e.exp_sat = model(chal, 7);
            sb.push_back(e);
        end
        @(negedge clock);
        bus.challenge = chal;
        bus.start     = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        cyc = 0;
        while (cyc < LAT + 20) begin
            @(posedge clock);
            #1;
            cyc++;
            if (bus.done === 1'b1) break;
            if (cyc == 1) begin
                check({tag, "/busy_rise"}, 32'(bus.busy), 32'd1);
                check({tag, "/valid_clr"}, 32'(bus.resp_valid), 32'd0);
            end
            if (cyc == 10) check({tag, "/ro_en"}, 32'(bus.ro_enable), 32'd1);
            if (poke && cyc == 20) begin
                bus.start     = 1'b1;
                bus.challenge = ~chal;
            end
            if (poke && cyc == 21) bus.start = 1'b0;
            if (abort_at != 0 && cyc == abort_at) begin
                reset = 1'b0;
                @(posedge clock);
                #1;
                check({tag, "/rst_busy"}, 32'(bus.busy), 32'd0);
                check({tag, "/rst_ro_en"}, 32'(bus.ro_enable), 32'd0);
                check({tag, "/rst_resp"}, 32'(bus.response), 32'd0);
                check({tag, "/rst_valid"}, 32'(bus.resp_valid), 32'd0);
                reset = 1'b1;
                return;
            end
        end
        check({tag, "/latency"}, cyc, LAT);
        check({tag, "/busy_done"}, 32'(bus.busy), 32'd0);
        check({tag, "/valid"}, 32'(bus.resp_valid), 32'd1);
        check({tag, "/ro_en_done"}, 32'(bus.ro_enable), 32'd0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, "/response"}, 32'(bus.response), 32'(e.exp));
            check({e.tag, "/sat_response"}, 32'(sat_bus.response), 32'(e.exp_sat));
        end
        @(posedge clock);
        #1;
        check({tag, "/done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        logic [NUM_RO-1:0] m;
        bus.start     = 1'b0;
        bus.challenge = '0;
        reset         = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset/busy", 32'(bus.busy), 32'd0);
        check("reset/done", 32'(bus.done), 32'd0);
        check("reset/valid", 32'(bus.resp_valid), 32'd0);
        check("reset/response", 32'(bus.response), 32'd0);
        check("reset/ro_en", 32'(bus.ro_enable), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // A stronger: period 4 vs 8 on every oscillator.
        mask_a = '1; mask_b = '1; per_a = 4; per_b = 8;
        run("a_strong", 8'h5A, 1'b0, 0);
        // B stronger.
        per_a = 8; per_b = 4;
        run("b_strong", 8'h5A, 1'b0, 0);
        // Identical period and phase: tie gives 0, saturated counters tie too.
        per_a = 4; per_b = 4;
        run("tie", 8'hC3, 1'b0, 0);
        // Only the selected bank-A oscillators toggle.
        m = '0;
        for (int i = 0; i < RESP_W; i++) m[sel_a_of(8'h03, i)] = 1'b1;
        mask_a = m; mask_b = '0; per_a = 4; per_b = 8;
        run("select_all", 8'h03, 1'b0, 0);
        // Only bits 0 and 3 select a toggling oscillator.
        m = '0;
        m[sel_a_of(8'h03, 0)] = 1'b1;
        m[sel_a_of(8'h03, 3)] = 1'b1;
        mask_a = m;
        run("select_part", 8'h03, 1'b0, 0);
        // Counts of about 10 vs 8: full counters give 1, 3-bit counters saturate to a tie.
        mask_a = '1; mask_b = '1; per_a = 6; per_b = 8;
        run("saturate", 8'h77, 1'b0, 0);
        // Start pulse during a run is ignored.
        per_a = 4; per_b = 8;
        run("ignored_start", 8'h5A, 1'b1, 0);
        // Reset in the middle of a COUNT window, then a clean run.
        run("abort", 8'h5A, 1'b0, 200);
        mask_b = 16'h0F0F; per_a = 8; per_b = 4;
        run("recover", 8'h4B, 1'b0, 0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
